// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits MSB first, 1 start, 1 stop, no parity, runtime bit-period divisor.
// Define UART_RX_MAJORITY_EN to make line decisions from a 2-of-3 majority of recent samples.
module uart_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [23:0] divisor_i,
    input  logic        rx_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        frame_err_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [23:0] div_q, div_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        frame_err_q, frame_err_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_dec;
    logic [23:0]            half_div;

    // Synchronizer flops reset high so the line looks idle out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    // Two previous samples; together with rx_s they form the 3-sample vote window.
    logic [1:0] hist_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign rx_dec = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign rx_dec = rx_s;
`endif

    assign half_div = {1'b0, div_q[23:1]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Start detection deliberately uses the raw synchronized line.
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = '0;
                    div_d   = divisor_i;
                end
            end
            StStart: begin
                if (cnt_q != half_div) begin
                    cnt_d = cnt_q + 24'd1;
                end else if (rx_dec) begin
                    state_d = StIdle;
                end else begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (cnt_q != div_q) begin
                    cnt_d = cnt_q + 24'd1;
                end else begin
                    shreg_d   = {shreg_q[6:0], rx_dec};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q != div_q) begin
                    cnt_d = cnt_q + 24'd1;
                end else begin
                    cnt_d = '0;
                    if (rx_dec) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                // Holding here until the line recovers keeps a break from retriggering.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART serial-to-parallel receiver: 8 data bits, MSB first, one start bit (0), one stop bit (1), no parity; idle line high.
- Bit period is divisor+1 clk cycles, set by the same runtime 24-bit divisor the team's UART transmit path uses.
- Sits at the board RX pin; delivers each received byte with a one-cycle valid strobe and flags framing errors.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the rx input synchronizer (allowed: 2 or 3).

Ports:
- clk  input  1  system clock; all logic is on its posedge.
- rst_n  input  1  asynchronous, active-low reset.
- divisor  input  24  bit period minus 1, in clk cycles. Minimum legal value is 3.
- rx  input  1  asynchronous serial line.
- data  output  8  last correctly framed byte.
- valid  output  1  one-cycle strobe when data updates.
- frame_err  output  1  one-cycle strobe on a bad stop bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, data=8'h00, valid=0, frame_err=0, busy=0, counters=0, synchronizer flops=1 (line idle).
- rx_s is rx after SYNC_STAGES flops. The FSM sees only rx_s.
- div_l latches divisor on the IDLE->START transition. A divisor change mid-frame takes effect on the next frame only.
- IDLE: when rx_s==0, go to START with cnt<=0.
- START:
  - While cnt != div_l>>1, increment cnt.
  - At cnt == div_l>>1, if rx_s==1 (glitch), return to IDLE with no strobe.
  - Otherwise cnt<=0, bit_idx<=0, go to DATA.
- DATA:
  - While cnt != div_l, increment cnt.
  - At cnt == div_l: shreg <= {shreg[6:0], rx_s}, so the first received bit ends in bit 7. Then cnt<=0 and bit_idx++.
  - After the 8th sample, go to STOP.
- STOP: at cnt == div_l, sample rx_s.
  - If 1: data<=shreg and valid=1 for exactly that cycle; go to IDLE.
  - If 0: frame_err=1 for one cycle; data is unchanged; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. A break or stuck-low line yields exactly one frame_err and never retriggers.
- valid and frame_err are never high together; both are registered.
- Latency (SYNC_STAGES=2): valid rises at clk edge 3 + (div_l>>1) + 1 + 9*(div_l+1), counted from the first edge after the rx falling edge. With divisor=15 that is edge 155.
- Back-to-back frames: a start bit that immediately follows the stop-sample point is accepted. IDLE is re-entered in time because sampling is mid-bit.
- rst_n low mid-frame: immediate return to reset values, partial byte discarded, no strobe.
- divisor<3: behaviour undefined; the bench must not drive it.

Optional Feature:
- UART_RX_MAJORITY_EN defined:
  - Each START check, DATA sample and STOP sample uses the 2-of-3 majority of rx_s at the current cycle and the two previous cycles (3-bit history register).
  - IDLE start detection still uses raw rx_s.
  - Timing is unchanged.
- UART_RX_MAJORITY_EN undefined: single-sample decisions and no history register.

Test Plan:
- divisor=15, send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1) -> data=8'hA5, valid high exactly one cycle at edge 155, frame_err stays 0.
- divisor=15, send 0x55 then 0xC3 back-to-back with no idle gap -> two valid strobes 160 cycles apart, data=0x55 then 0xC3.
- divisor=15, rx low for 4 cycles then high -> START rejects the glitch, returns to IDLE, no valid or frame_err; busy drops about 11 cycles after the fall.
- divisor=15, send 0x3C with stop bit 0 and hold rx low for 100 more cycles -> one frame_err pulse, data keeps its previous value, no valid; next good frame is received normally.
- divisor=15, assert rst_n=0 mid-DATA on bit 4 -> outputs at reset values immediately; a later 0x81 frame is received correctly.
- With UART_RX_MAJORITY_EN: 0xF0 frame with a one-cycle inverted spike at each sample point -> data=0xF0. Without the macro the same stimulus -> data differs, demonstrating the filter.
